midi_byte_parser: RTL

//   Downstream consumer of the UART receiver in the MIDI synth path. Pops received bytes
//   via the UART's valid/read-strobe interface, parses the MIDI channel-voice protocol
//   (running status, 1- and 2-data-byte messages, realtime/sysex skipping) and presents
//   one decoded event at a time on a valid/ready port to the voice allocator.

---
 rtl/midi_byte_parser.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/midi_byte_parser.sv
// midi_byte_parser: pops bytes from the UART receive buffer, parses MIDI
// channel-voice messages (running status, 1/2 data-byte messages, realtime
// pass-over, sysex/system-common skipping) and presents one decoded event
// at a time on a valid/ready port.
//
// Optional feature macro: MIDI_PARSER_CHANNEL_FILTER_EN
//   defined   : only completed messages on channel MIDI_CHANNEL raise an event
//   undefined : events for all 16 channels, MIDI_CHANNEL unused
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   rx_valid, rx_data    UART buffered byte and its valid
//   rx_re                read strobe to UART (combinational), byte taken this edge
//   ev_valid, ev_ready   event handshake, event held until accepted
//   ev_type, ev_chan     status[6:4] (note-on vel 0 reported as 0), status[3:0]
//   ev_data1, ev_data2   data bytes (ev_data2 = 0 for 1-data-byte messages)
module midi_byte_parser #(
  parameter int unsigned MIDI_CHANNEL = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_re,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_type,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_data1,
  output logic [6:0] ev_data2
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned DATA_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SKIP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TYPE_W-1:0]   rs_type_q, rs_type_d;
  logic [CHAN_W-1:0]   rs_chan_q, rs_chan_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic                ev_valid_q, ev_valid_d;
  logic [TYPE_W-1:0]   ev_type_q, ev_type_d;
  logic [CHAN_W-1:0]   ev_chan_q, ev_chan_d;
  logic [DATA_W-1:0]   ev_data1_q, ev_data1_d;
  logic [DATA_W-1:0]   ev_data2_q, ev_data2_d;

  logic                emit_c;
  logic [DATA_W-1:0]   emit_d2_c;
  logic                chan_ok_c;
  logic                one_byte_c;

  // Never pop a byte while an event is still waiting for the consumer.
  assign rx_re = rx_valid & ~ev_valid_q;

  // Program change and channel aftertouch carry a single data byte.
  assign one_byte_c = (rs_type_q == TYPE_W'(4)) || (rs_type_q == TYPE_W'(5));

`ifdef MIDI_PARSER_CHANNEL_FILTER_EN
  localparam logic [CHAN_W-1:0] FILT_CHAN = CHAN_W'(MIDI_CHANNEL);
  assign chan_ok_c = (rs_chan_q == FILT_CHAN);
`else
  logic unused_chan_c;
  assign unused_chan_c = ^32'(MIDI_CHANNEL);
  assign chan_ok_c     = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rs_type_q  <= '0;
      rs_chan_q  <= '0;
      d1_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_type_q  <= '0;
      ev_chan_q  <= '0;
      ev_data1_q <= '0;
      ev_data2_q <= '0;
    end else begin
      state_q    <= state_d;
      rs_type_q  <= rs_type_d;
      rs_chan_q  <= rs_chan_d;
      d1_q       <= d1_d;
      ev_valid_q <= ev_valid_d;
      ev_type_q  <= ev_type_d;
      ev_chan_q  <= ev_chan_d;
      ev_data1_q <= ev_data1_d;
      ev_data2_q <= ev_data2_d;
    end
  end

  // Byte classification, message assembly and event generation
  always_comb begin
    state_d    = state_q;
    rs_type_d  = rs_type_q;
    rs_chan_d  = rs_chan_q;
    d1_d       = d1_q;
    ev_valid_d = ev_valid_q;
    ev_type_d  = ev_type_q;
    ev_chan_d  = ev_chan_q;
    ev_data1_d = ev_data1_q;
    ev_data2_d = ev_data2_q;
    emit_c     = 1'b0;
    emit_d2_c  = '0;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (rx_re) begin
      if (rx_data[7]) begin
        if (rx_data[7:4] != 4'hF) begin
          // Channel status: new running status, any partial message dropped.
          rs_type_d = rx_data[6:4];
          rs_chan_d = rx_data[3:0];
          state_d   = WAIT_D1;
        end else if (!rx_data[3]) begin
          // System common / sysex: running status lost until next status.
          rs_type_d = '0;
          rs_chan_d = '0;
          state_d   = SKIP;
        end
        // 0xF8-0xFF realtime bytes fall through untouched.
      end else begin
        unique case (state_q)
          WAIT_D1: begin
            d1_d = rx_data[6:0];
            if (one_byte_c) begin
              emit_c = 1'b1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit_c    = 1'b1;
            emit_d2_c = rx_data[6:0];
            state_d   = WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    // emit_c only happens with rx_re, i.e. while no event is pending.
    if (emit_c && chan_ok_c) begin
      ev_valid_d = 1'b1;
      ev_type_d  = ((rs_type_q == TYPE_W'(1)) && (emit_d2_c == '0)) ? TYPE_W'(0) : rs_type_q;
      ev_chan_d  = rs_chan_q;
      ev_data1_d = d1_d;
      ev_data2_d = emit_d2_c;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_type  = ev_type_q;
  assign ev_chan  = ev_chan_q;
  assign ev_data1 = ev_data1_q;
  assign ev_data2 = ev_data2_q;

endmodule
